// File: rtl/bp_fe_pkg.sv
// Front-end shared types: fetch-buffer exception codes, response classes,
// and the fetch-buffer entry struct macro.
`define BP_FE_DECLARE_FETCH_BUFFER_ENTRY_S(vaddr_width_mp, instr_width_mp) \
  typedef struct packed {                                                 \
    logic [vaddr_width_mp-1:0]   pc;                                      \
    logic [instr_width_mp-1:0]   instr;                                   \
    bp_fe_pkg::bp_fe_fetch_exc_e exc;                                     \
  } bp_fe_fetch_buffer_entry_s

package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_fetch_exc_none         = 2'd0,
    e_fetch_exc_rsvd         = 2'd1,
    e_fetch_exc_page_fault   = 2'd2,
    e_fetch_exc_access_fault = 2'd3
  } bp_fe_fetch_exc_e;

  typedef enum logic [2:0] {
    e_resp_none,
    e_resp_itlb_miss,
    e_resp_page_fault,
    e_resp_access_fault,
    e_resp_icache_miss
  } bp_fe_resp_class_e;

  // itlb miss outranks faults because the translation itself is not yet valid.
  function automatic bp_fe_resp_class_e bp_fe_classify_resp(
    input logic itlb_miss,
    input logic icache_miss,
    input logic page_fault,
    input logic access_fault
  );
    if (itlb_miss)         return e_resp_itlb_miss;
    else if (page_fault)   return e_resp_page_fault;
    else if (access_fault) return e_resp_access_fault;
    else if (icache_miss)  return e_resp_icache_miss;
    else                   return e_resp_none;
  endfunction

endpackage

// File: rtl/bp_fe_fetch_fifo.sv
// Circular buffer with naturally wrapping pointers and a separate occupancy
// counter; clear_i empties it synchronously and overrides enq/deq.
module bp_fe_fetch_fifo #(
  parameter  int width_p  = 8,
  parameter  int els_p    = 4,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = ptr_w_lp + 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                enq_v_i,
  input  logic [width_p-1:0]  enq_data_i,
  input  logic                deq_yumi_i,
  output logic                deq_v_o,
  output logic [width_p-1:0]  deq_data_o,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                enq, deq;

  assign enq = enq_v_i & ~clear_i;
  assign deq = deq_yumi_i & ~clear_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + ptr_w_lp'(1);
      if (deq) rptr_d = rptr_q + ptr_w_lp'(1);
      count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= enq_data_i;
  end

  assign deq_v_o    = (count_q != '0);
  assign deq_data_o = mem_q[rptr_q];
  assign count_o    = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(enq && !deq && count_q == cnt_w_lp'(els_p)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(deq_yumi_i && count_q == '0));

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// Pairs two-cycle memory-stage responses with their PCs, classifies them into
// replay misses or buffered entries, and grants fetch credits.
module bp_fe_fetch_buffer
  import bp_fe_pkg::*;
#(
  parameter  int vaddr_width_p  = 39,
  parameter  int instr_width_p  = 32,
  parameter  int fifo_els_p     = 4,
  localparam int count_width_lp = $clog2(fifo_els_p) + 1,
  localparam int credit_w_lp    = count_width_lp + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      fetch_v_i,
  input  logic [vaddr_width_p-1:0]  fetch_pc_i,
  output logic                      fetch_ready_o,
  input  logic                      poison_i,
  input  logic                      flush_i,
  input  logic                      resp_v_i,
  input  logic [instr_width_p-1:0]  resp_instr_i,
  input  logic                      resp_itlb_miss_i,
  input  logic                      resp_icache_miss_i,
  input  logic                      resp_page_fault_i,
  input  logic                      resp_access_fault_i,
  output logic                      miss_v_o,
  output logic [vaddr_width_p-1:0]  miss_pc_o,
  output logic                      miss_itlb_o,
  output logic                      deq_v_o,
  output logic [vaddr_width_p-1:0]  deq_pc_o,
  output logic [instr_width_p-1:0]  deq_instr_o,
  output logic [1:0]                deq_exc_o,
  input  logic                      deq_yumi_i,
  output logic [count_width_lp-1:0] count_o
);

  `BP_FE_DECLARE_FETCH_BUFFER_ENTRY_S(vaddr_width_p, instr_width_p);

  logic                      s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [vaddr_width_p-1:0]  s1_pc_q, s1_pc_d, s2_pc_q, s2_pc_d;
  bp_fe_resp_class_e         resp_class;
  logic                      consume, kill, enq_v;
  bp_fe_fetch_buffer_entry_s enq_entry, deq_entry;
  logic [count_width_lp-1:0] fifo_count;
  logic [credit_w_lp-1:0]    credits_used;

  always_comb begin
    resp_class = bp_fe_classify_resp(resp_itlb_miss_i, resp_icache_miss_i,
                                     resp_page_fault_i, resp_access_fault_i);
    consume    = s2_v_q & ~flush_i;
    kill       = consume & (resp_class != e_resp_none);

    s1_v_d  = fetch_v_i;
    s1_pc_d = fetch_pc_i;
    s2_v_d  = s1_v_q & ~poison_i & ~flush_i & ~kill;
    s2_pc_d = s1_pc_q;

    miss_v_o    = consume & ((resp_class == e_resp_itlb_miss) | (resp_class == e_resp_icache_miss));
    miss_itlb_o = (resp_class == e_resp_itlb_miss);
    miss_pc_o   = s2_pc_q;

    enq_v           = consume & ~miss_v_o;
    enq_entry.pc    = s2_pc_q;
    enq_entry.instr = (resp_class == e_resp_none) ? resp_instr_i : '0;
    case (resp_class)
      e_resp_page_fault:   enq_entry.exc = e_fetch_exc_page_fault;
      e_resp_access_fault: enq_entry.exc = e_fetch_exc_access_fault;
      default:             enq_entry.exc = e_fetch_exc_none;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s1_pc_q <= '0;
      s2_pc_q <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      s1_pc_q <= s1_pc_d;
      s2_pc_q <= s2_pc_d;
    end
  end

  bp_fe_fetch_fifo #(
    .width_p($bits(bp_fe_fetch_buffer_entry_s)),
    .els_p  (fifo_els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (flush_i),
    .enq_v_i   (enq_v),
    .enq_data_i(enq_entry),
    .deq_yumi_i(deq_yumi_i),
    .deq_v_o   (deq_v_o),
    .deq_data_o(deq_entry),
    .count_o   (fifo_count)
  );

  // Every in-flight fetch may still land in the buffer, so it holds a slot.
  assign credits_used  = credit_w_lp'(fifo_count) + credit_w_lp'(s1_v_q) + credit_w_lp'(s2_v_q);
  assign fetch_ready_o = (credits_used < credit_w_lp'(fifo_els_p));

  assign deq_pc_o    = deq_entry.pc;
  assign deq_instr_o = deq_entry.instr;
  assign deq_exc_o   = deq_entry.exc;
  assign count_o     = fifo_count;

  a_resp_aligned: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    resp_v_i == s2_v_q);

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Directed scenarios plus random traffic against an outstanding-fetch /
// queue reference model of the fetch buffer.
module tb_bp_fe_fetch_buffer;
  localparam int VW  = 39;
  localparam int IW  = 32;
  localparam int ELS = 4;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          fetch_v_i = 1'b0, poison_i = 1'b0, flush_i = 1'b0, deq_yumi_i = 1'b0;
  logic [VW-1:0] fetch_pc_i = '0;
  logic          resp_v_i = 1'b0;
  logic [IW-1:0] resp_instr_i = '0;
  logic          resp_itlb_miss_i = 1'b0, resp_icache_miss_i = 1'b0;
  logic          resp_page_fault_i = 1'b0, resp_access_fault_i = 1'b0;
  logic          fetch_ready_o, miss_v_o, miss_itlb_o, deq_v_o;
  logic [VW-1:0] miss_pc_o, deq_pc_o;
  logic [IW-1:0] deq_instr_o;
  logic [1:0]    deq_exc_o;
  logic [2:0]    count_o;

  always #5 clk = ~clk;

  bp_fe_fetch_buffer #(.vaddr_width_p(VW), .instr_width_p(IW), .fifo_els_p(ELS)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .fetch_ready_o(fetch_ready_o),
    .poison_i(poison_i), .flush_i(flush_i),
    .resp_v_i(resp_v_i), .resp_instr_i(resp_instr_i),
    .resp_itlb_miss_i(resp_itlb_miss_i), .resp_icache_miss_i(resp_icache_miss_i),
    .resp_page_fault_i(resp_page_fault_i), .resp_access_fault_i(resp_access_fault_i),
    .miss_v_o(miss_v_o), .miss_pc_o(miss_pc_o), .miss_itlb_o(miss_itlb_o),
    .deq_v_o(deq_v_o), .deq_pc_o(deq_pc_o), .deq_instr_o(deq_instr_o),
    .deq_exc_o(deq_exc_o), .deq_yumi_i(deq_yumi_i), .count_o(count_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: outstanding fetches with their age (1 = issued last
  // cycle, 2 = response due now) and the buffered entries in order.
  typedef struct { logic [VW-1:0] pc; int age; } flight_t;
  typedef struct { logic [VW-1:0] pc; logic [IW-1:0] instr; logic [1:0] exc; } ent_t;
  flight_t infl[$];
  ent_t    fifo_m[$];

  // flags: [0]=itlb miss [1]=icache miss [2]=page fault [3]=access fault
  // class: 0=itlb 1=page fault 2=access fault 3=icache 4=hit
  function automatic int classify_m(input logic [3:0] f);
    if (f[0]) return 0;
    if (f[2]) return 1;
    if (f[3]) return 2;
    if (f[1]) return 3;
    return 4;
  endfunction

  task automatic step(input logic fv, input logic [VW-1:0] fpc, input logic pois,
                      input logic fl, input logic yumi, input logic [3:0] flags,
                      input logic [IW-1:0] instr);
    int      r2;
    int      cls;
    logic    issue, yumi_eff, exp_miss, killed;
    ent_t    e;
    flight_t nq[$];
    r2 = -1;
    foreach (infl[i]) if (infl[i].age == 2) r2 = i;
    issue    = fv && ((fifo_m.size() + infl.size() < ELS) || fl);
    yumi_eff = yumi && (fifo_m.size() != 0);
    fetch_v_i = issue; fetch_pc_i = fpc; poison_i = pois; flush_i = fl;
    deq_yumi_i = yumi_eff; resp_v_i = (r2 >= 0); resp_instr_i = instr;
    resp_itlb_miss_i = flags[0]; resp_icache_miss_i = flags[1];
    resp_page_fault_i = flags[2]; resp_access_fault_i = flags[3];
    #1;
    cls      = classify_m(flags);
    exp_miss = (r2 >= 0) && !fl && (cls == 0 || cls == 3);
    check("count", count_o, fifo_m.size());
    check("deq_v", deq_v_o, fifo_m.size() != 0);
    check("fetch_ready", fetch_ready_o, (fifo_m.size() + infl.size()) < ELS);
    check("miss_v", miss_v_o, exp_miss);
    if (fifo_m.size() != 0) begin
      check("deq_pc", deq_pc_o, fifo_m[0].pc);
      check("deq_instr", deq_instr_o, fifo_m[0].instr);
      check("deq_exc", deq_exc_o, fifo_m[0].exc);
    end
    if (exp_miss) begin
      check("miss_pc", miss_pc_o, infl[r2].pc);
      check("miss_itlb", miss_itlb_o, cls == 0);
    end
    @(posedge clk);
    if (fl) begin
      fifo_m.delete();
      infl.delete();
    end else begin
      if (yumi_eff) begin
        $display("txn deq pc=%h instr=%h exc=%0d", fifo_m[0].pc, fifo_m[0].instr, fifo_m[0].exc);
        void'(fifo_m.pop_front());
      end
      killed = (r2 >= 0) && (cls != 4);
      if (r2 >= 0 && cls != 0 && cls != 3) begin
        e.pc    = infl[r2].pc;
        e.instr = (cls == 4) ? instr : '0;
        e.exc   = (cls == 1) ? 2'd2 : (cls == 2) ? 2'd3 : 2'd0;
        fifo_m.push_back(e);
      end
      foreach (infl[i]) if (infl[i].age == 1 && !pois && !killed) nq.push_back(infl[i]);
      infl = nq;
    end
    foreach (infl[i]) infl[i].age++;
    if (issue) infl.push_back('{pc: fpc, age: 1});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'b0, '0);
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && (fifo_m.size() + infl.size()) != 0; k++)
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'b0, '0);
    check("drain_empty", count_o, 0);
  endtask

  logic [VW-1:0] rpc;
  logic [3:0]    rflags;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_deq_v", deq_v_o, 0);
    check("rst_miss_v", miss_v_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ready", fetch_ready_o, 1);
    reset_n_i = 1'b1;
    @(negedge clk);

    // three sequential hits, no dequeue
    step(1'b1, 39'h8000_0000, 0, 0, 0, 4'b0, 32'h1111_0001);
    step(1'b1, 39'h8000_0004, 0, 0, 0, 4'b0, 32'h1111_0002);
    step(1'b1, 39'h8000_0008, 0, 0, 0, 4'b0, 32'h1111_0003);
    idle(3);
    check("seq_count3", count_o, 3);
    drain();

    // backpressure: back-to-back attempts, nothing consumed
    for (int k = 0; k < 8; k++)
      step(1'b1, 39'h8000_0100 + 39'(4 * k), 0, 0, 0, 4'b0, 32'hA000_0000 + 32'(k));
    check("bp_count4", count_o, 4);
    check("bp_ready0", fetch_ready_o, 0);
    drain();

    // icache miss on 0x10 while 0x14 sits in stage 1
    step(1'b1, 39'h8000_0010, 0, 0, 0, 4'b0, '0);
    step(1'b1, 39'h8000_0014, 0, 0, 0, 4'b0, '0);
    step(1'b0, '0, 0, 0, 0, 4'b0010, 32'hDEAD_0010);
    idle(3);
    drain();

    // itlb miss and page fault together: itlb wins
    step(1'b1, 39'h1000, 0, 0, 0, 4'b0, '0);
    idle(1);
    step(1'b0, '0, 0, 0, 0, 4'b0101, 32'hDEAD_1000);
    idle(2);

    // page fault alone: enqueued with zeroed instruction
    step(1'b1, 39'h2000, 0, 0, 0, 4'b0, '0);
    idle(1);
    step(1'b0, '0, 0, 0, 0, 4'b0100, 32'hDEAD_2000);
    idle(1);
    drain();

    // flush with three buffered entries, a live response and a new fetch
    for (int k = 0; k < 5; k++)
      step(1'b1, 39'h8000_0200 + 39'(4 * k), 0, 0, 0, 4'b0, 32'hB000_0000 + 32'(k));
    check("fl_pre_count", count_o, 3);
    step(1'b1, 39'h9000, 0, 1, 1, 4'b0, 32'hB000_00FF);
    check("fl_post_count", count_o, 0);
    step(1'b0, '0, 0, 0, 0, 4'b0, '0);
    step(1'b0, '0, 0, 0, 0, 4'b0, 32'hC000_9000);
    drain();

    // poison the fetch the cycle after issue
    step(1'b1, 39'h3000, 0, 0, 0, 4'b0, '0);
    step(1'b0, '0, 1, 0, 0, 4'b0, '0);
    idle(3);

    // asynchronous reset with two buffered entries and two fetches in flight
    for (int k = 0; k < 4; k++)
      step(1'b1, 39'h8000_0300 + 39'(4 * k), 0, 0, 0, 4'b0, 32'hE000_0000 + 32'(k));
    resp_v_i = 1'b1;
    #2;
    reset_n_i = 1'b0;
    #1;
    check("arst_deq_v", deq_v_o, 0);
    check("arst_miss_v", miss_v_o, 0);
    check("arst_count", count_o, 0);
    check("arst_ready", fetch_ready_o, 1);
    fetch_v_i = 0; resp_v_i = 0; poison_i = 0; flush_i = 0; deq_yumi_i = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n_i = 1'b1;
    infl.delete();
    fifo_m.delete();
    @(negedge clk);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      rpc    = VW'({$urandom(), $urandom()}) & ~VW'(3);
      rflags = {($urandom_range(7) == 0), ($urandom_range(7) == 0),
                ($urandom_range(7) == 0), ($urandom_range(7) == 0)};
      step(($urandom_range(3) != 0), rpc, ($urandom_range(11) == 0),
           ($urandom_range(39) == 0), ($urandom_range(2) != 0), rflags, $urandom());
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bp_fe_fetch_buffer.md
Name: bp_fe_fetch_buffer

Overview:
- Sits directly downstream of the FE memory stage (itlb + icache). Consumes its two-cycle fetch response and pairs each response with the PC that issued it.
- Buffers completed instructions and fault records in a small circular FIFO for the fe_queue writer.
- Reports replayable misses (itlb/icache) to the PC generator.
- Issues credit-based fetch_ready_o, so a fetch is never launched without a guaranteed buffer slot.

Parameters:
- vaddr_width_p, 39, virtual PC width
- instr_width_p, 32, instruction width
- fifo_els_p, 4, buffer depth; power of two, >=2

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- fetch_v_i  in  1  memory stage accepted a fetch command this cycle
- fetch_pc_i  in  vaddr_width_p  PC of that fetch
- fetch_ready_o  out  1  credit available; pc_gen may issue a fetch
- poison_i  in  1  kill the fetch currently in stage 1 (issued last cycle)
- flush_i  in  1  redirect: discard buffer and all in-flight fetches
- resp_v_i  in  1  memory-stage response valid
- resp_instr_i  in  instr_width_p  fetched instruction
- resp_itlb_miss_i  in  1  itlb miss flag
- resp_icache_miss_i  in  1  icache miss flag
- resp_page_fault_i  in  1  page-fault flag
- resp_access_fault_i  in  1  access-fault flag
- miss_v_o  out  1  one-cycle replay request
- miss_pc_o  out  vaddr_width_p  PC to refetch
- miss_itlb_o  out  1  1 = itlb miss, 0 = icache miss
- deq_v_o  out  1  head entry valid
- deq_pc_o  out  vaddr_width_p  head PC
- deq_instr_o  out  instr_width_p  head instruction; zero for fault entries
- deq_exc_o  out  2  head exception code
- deq_yumi_i  in  1  consumer takes head this cycle
- count_o  out  log2(fifo_els_p)+1  occupied entries

Behaviour:
- Reset (async, reset_n_i=0) clears the FIFO, pointers, and stage-1/stage-2 valids.
  - Reset values: deq_v_o=0, miss_v_o=0, count_o=0, fetch_ready_o=1.
  - All pipeline state is discarded, including mid-flight fetches.
- In-flight tracking:
  - Stage 1: v_r <= fetch_v_i; pc_r <= fetch_pc_i.
  - Stage 2: v_rr <= v_r & ~poison_i & ~flush_i & ~kill; pc_rr <= pc_r.
  - kill: asserted the cycle a stage-2 response is a miss or a fault.
- Response alignment: resp_v_i must equal v_rr; mismatch is an assertion error. The response is consumed only when v_rr=1 and flush_i=0.
- Classification, by priority:
  - itlb_miss: miss_v_o=1, miss_itlb_o=1; not enqueued.
  - page_fault: enqueue with exc=2.
  - access_fault: enqueue with exc=3.
  - icache_miss: miss_v_o=1, miss_itlb_o=0; not enqueued.
  - none: enqueue with exc=0 and resp_instr_i.
  - miss_pc_o=pc_rr.
  - Any non-none class asserts kill. kill drops the stage-1 fetch next cycle but does not affect a fetch_v_i in the same cycle.
- Exception codes: 0=none, 2=page_fault, 3=access_fault. Code 1 is reserved.
- Credits:
  - fetch_ready_o = (count_r + v_r + v_rr) < fifo_els_p.
  - Computed from registered state only; no path from deq_yumi_i, resp_*, or flush_i.
- FIFO:
  - Read/write pointers are log2(fifo_els_p) bits and wrap naturally; count_r is a separate counter.
  - deq_v_o = (count_r != 0). Head outputs come from the registered array.
  - deq_yumi_i while empty is an assertion error.
  - Enqueue and dequeue in the same cycle leave count unchanged and advance both pointers.
  - Enqueue while full cannot occur under the credit rule; it is an assertion error.
- Flush (synchronous, level):
  - Next cycle: count=0, pointers=0, v_rr=0.
  - A response arriving in the flush cycle is dropped and miss_v_o is suppressed.
  - A deq_yumi_i in the flush cycle is ignored.
  - v_r <= fetch_v_i, so a new-path fetch issued in the flush cycle survives.
- Poison and flush together behave as flush.
- Latency: fetch_v_i at cycle t produces an enqueue at t+2, visible on deq_v_o at t+3, or miss_v_o at t+2.

Decomposition:
- bp_fe_pkg gains:
  - bp_fe_fetch_exc_e enum (2 bits).
  - `declare_bp_fe_fetch_buffer_entry_s(vaddr_width_p, instr_width_p) struct macro with fields pc, instr, exc.
- One sub-module, bp_fe_fetch_fifo: parameterised circular buffer (entry width, els) with count output and no internal credit logic.
- Classification, in-flight tracking, and credits stay in the top module.

Test Plan:
- Reset: fetch_v_i at PC 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles, all hits.
  - Required: deq entries in order with exc=0, deq_v_o first high 3 cycles after the first issue, count_o peaks at 3 with no dequeue.
- Backpressure: hold deq_yumi_i=0 and issue back-to-back fetches.
  - Required: fetch_ready_o falls once count+in-flight reaches 4; exactly 4 entries are stored; no overflow assertion fires.
- icache miss on PC 0x8000_0010 while 0x8000_0014 is in stage 1.
  - Required: miss_v_o=1, miss_pc_o=0x8000_0010, miss_itlb_o=0; 0x8000_0014 is never enqueued or reported.
- Page-fault and itlb-miss flags both set on PC 0x1000.
  - Required: miss_v_o=1 with miss_itlb_o=1; nothing is enqueued.
- Page fault alone on PC 0x2000.
  - Required: enqueued with deq_exc_o=2 and deq_instr_o=0.
- Full buffer of 3 entries: assert flush_i together with fetch_v_i at PC 0x9000 and a valid response.
  - Required: next cycle count_o=0 and the response is dropped; 0x9000 dequeues 2 cycles later.
- poison_i the cycle after a fetch.
  - Required: no enqueue and no miss_v_o for that fetch.
- Drop reset_n_i mid-stream with 2 entries buffered and 2 fetches in flight.
  - Required: all outputs go to their reset values immediately, without waiting for a clock edge.
